// File: rtl/traffic_ctrl_param.sv
// traffic_ctrl_param
//   N-approach intersection controller with configurable green, yellow and
//   all-red durations, optional demand-actuated rotation and emergency
//   preemption. One approach at most is non-red in any cycle.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous, active-low reset
//   car_req     per-approach vehicle-present sensor (level)
//   skip_en     1 = demand-actuated rotation, 0 = fixed rotation
//   emg_req     emergency preemption request (level)
//   emg_dir     approach to be given priority
//   lights      lamp code for approach i at [2i+1:2i]: 00 red, 01 yellow, 10 green
//   active_dir  approach currently owning green/yellow
//   emg_active  high while in emergency green
//
// There is no data handshake on this block: car_req, skip_en, emg_req and
// emg_dir are plain levels sampled on every rising clock edge, and all
// outputs are registers updated on that same edge.
module traffic_ctrl_param #(
  parameter int NUM_DIR       = 4,
  parameter int GREEN_CYCLES  = 8,
  parameter int YELLOW_CYCLES = 3,
  parameter int ALLRED_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_DIR-1:0]         car_req,
  input  logic                       skip_en,
  input  logic                       emg_req,
  input  logic [$clog2(NUM_DIR)-1:0] emg_dir,
  output logic [2*NUM_DIR-1:0]       lights,
  output logic [$clog2(NUM_DIR)-1:0] active_dir,
  output logic                       emg_active
);

  localparam int DW = $clog2(NUM_DIR);

  localparam logic [CNT_W-1:0] G_LOAD = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] Y_LOAD = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] A_LOAD = CNT_W'(ALLRED_CYCLES - 1);

  localparam logic [2*NUM_DIR-1:0] LIGHTS_RST = (2*NUM_DIR)'(2'b10);

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_ALLRED = 2'd2,
    ST_EMG    = 2'd3
  } state_t;

  // Current FSM state is kept as a named, typed register so checkers can
  // bind to it directly.
  state_t            state;
  logic [CNT_W-1:0]  cnt;

  state_t            state_n;
  logic [DW-1:0]     dir_n;
  logic [CNT_W-1:0]  cnt_n;
  logic [2*NUM_DIR-1:0] lights_n;

  logic              emg_ok;
  logic              other_req;
  logic [DW-1:0]     sel_dir;

  // (d + k) mod NUM_DIR, generic for non-power-of-two NUM_DIR.
  function automatic logic [DW-1:0] wrap_add(input logic [DW-1:0] d, input int k);
    int s;
    s = (int'(d) + k) % NUM_DIR;
    return DW'(s);
  endfunction

  // An out-of-range emergency target is treated as no request at all.
  assign emg_ok = emg_req && (int'(emg_dir) < NUM_DIR);

  // Any approach other than the current owner asking for service.
  always_comb begin
    other_req = 1'b0;
    for (int j = 0; j < NUM_DIR; j++) begin
      if ((DW'(j) != active_dir) && car_req[j]) other_req = 1'b1;
    end
  end

  // Next owner: fixed rotation, or the first requesting approach found
  // cyclically after the current one (falling back to plain rotation).
  always_comb begin
    logic found;
    found   = 1'b0;
    sel_dir = wrap_add(active_dir, 1);
    if (skip_en) begin
      for (int i = 1; i <= NUM_DIR; i++) begin
        if (!found && car_req[wrap_add(active_dir, i)]) begin
          sel_dir = wrap_add(active_dir, i);
          found   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_n = state;
    dir_n   = active_dir;
    cnt_n   = cnt;
    case (state)
      ST_GREEN: begin
        if (emg_ok && (emg_dir == active_dir)) begin
          // Same approach: promote in place, lamp stays green.
          state_n = ST_EMG;
        end else if (emg_ok) begin
          // Different approach: cut green short, full yellow follows.
          state_n = ST_YELLOW;
          cnt_n   = Y_LOAD;
        end else if (cnt == '0) begin
          if (!skip_en || other_req) begin
            state_n = ST_YELLOW;
            cnt_n   = Y_LOAD;
          end else begin
            // Nobody else waiting: extend this green by a full phase.
            cnt_n = G_LOAD;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      ST_YELLOW: begin
        if (cnt == '0) begin
          state_n = ST_ALLRED;
          cnt_n   = A_LOAD;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      ST_ALLRED: begin
        if (cnt == '0) begin
          if (emg_ok) begin
            state_n = ST_EMG;
            dir_n   = emg_dir;
          end else begin
            state_n = ST_GREEN;
            dir_n   = sel_dir;
            cnt_n   = G_LOAD;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: begin
        // Emergency green is held untimed; only release of emg_req ends it,
        // and emg_dir changes meanwhile have no effect.
        if (!emg_req) begin
          state_n = ST_YELLOW;
          cnt_n   = Y_LOAD;
        end
      end
    endcase
  end

  // Lamp pattern is decoded from the next state so lights is a pure register.
  always_comb begin
    logic [1:0] code;
    case (state_n)
      ST_GREEN, ST_EMG: code = 2'b10;
      ST_YELLOW:        code = 2'b01;
      default:          code = 2'b00;
    endcase
    lights_n = '0;
    for (int i = 0; i < NUM_DIR; i++) begin
      if (DW'(i) == dir_n) lights_n[2*i +: 2] = code;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_GREEN;
      active_dir <= '0;
      cnt        <= G_LOAD;
      lights     <= LIGHTS_RST;
      emg_active <= 1'b0;
    end else begin
      state      <= state_n;
      active_dir <= dir_n;
      cnt        <= cnt_n;
      lights     <= lights_n;
      emg_active <= (state_n == ST_EMG);
    end
  end

endmodule

// File: doc/traffic_ctrl_param.md
Name: traffic_ctrl_param

Overview:
- Parametrised N-approach intersection controller; successor of the fixed 4-way FSM_Traffic_Control.
- Adds configurable phase durations, an all-red clearance interval and vehicle-sensor skipping (demand actuation).
- Adds emergency preemption.
- Sits at the top of the traffic subsystem, driving per-approach 2-bit lamp codes.

Parameters:
NUM_DIR, 4, number of approaches (2..8), index 0 = North, clockwise
GREEN_CYCLES, 8, green duration in clocks (>=1)
YELLOW_CYCLES, 3, yellow duration in clocks (>=1)
ALLRED_CYCLES, 1, all-red clearance in clocks (>=1)
CNT_W, 8, phase counter width; every duration minus 1 must fit

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-low reset
car_req  in  NUM_DIR  per-approach vehicle-present sensor, level
skip_en  in  1  1 = demand-actuated rotation, 0 = fixed rotation
emg_req  in  1  emergency preemption request, level
emg_dir  in  $clog2(NUM_DIR)  approach to be given priority
lights  out  2*NUM_DIR  lamp code for approach i at [2i+1:2i]
active_dir  out  $clog2(NUM_DIR)  approach currently owning green/yellow
emg_active  out  1  high while in EMG_GREEN

Behaviour:
- Lamp encoding: 00 red, 01 yellow, 10 green, 11 never driven.
- All outputs are registered.
- At most one approach is non-red in any cycle.
- States:
  - GREEN: active_dir = 10, others = 00.
  - YELLOW: active_dir = 01.
  - ALLRED: all 00.
  - EMG_GREEN: active_dir = 10.
- Phase counter: loaded with DUR-1 on entry and decremented each clock; the state exits on the cycle it reads 0. Each phase therefore lasts exactly DUR clocks.
- Reset (rst=0 at a clock edge):
  - state = GREEN, active_dir = 0, counter = GREEN_CYCLES-1.
  - lights = approach 0 green, all others red; emg_active = 0.
  - Reset mid-phase aborts the phase immediately; no yellow is inserted.
- GREEN expiry, normal case (emg_req=0):
  - skip_en=0: go to YELLOW.
  - skip_en=1 and some other approach has car_req=1: go to YELLOW.
  - skip_en=1 and no other approach has car_req: stay GREEN and reload the counter (green extension).
- YELLOW expiry: go to ALLRED.
- ALLRED expiry: go to GREEN with a new active_dir, chosen as follows:
  - Pending emergency (emg_req=1): active_dir = emg_dir, enter EMG_GREEN.
  - skip_en=0: active_dir = (active_dir+1) mod NUM_DIR.
  - skip_en=1: first approach with car_req=1 found by searching cyclically from active_dir+1. If none, use (active_dir+1) mod NUM_DIR.
- Emergency request in GREEN:
  - emg_req=1 and emg_dir==active_dir: enter EMG_GREEN next cycle; lamp stays green with no glitch.
  - emg_req=1 and emg_dir!=active_dir: green truncates at once; YELLOW is entered next cycle with full YELLOW_CYCLES.
- Emergency request in YELLOW or ALLRED: the phase completes normally; the target is redirected at ALLRED expiry.
- EMG_GREEN:
  - emg_active=1; the phase is held with no counter while emg_req=1.
  - When emg_req falls: go to YELLOW for that approach, then ALLRED, then normal selection from that approach.
  - emg_dir changes while held: ignored until emg_req deasserts.
- emg_dir >= NUM_DIR: the request is ignored (treated as emg_req=0).
- Counter and selection logic is generic in NUM_DIR; wrap from NUM_DIR-1 to 0.

Test Plan:
1. Fixed rotation (defaults; skip_en=0, emg_req=0); release rst at t0.
   - Approach 0: green cycles 0-7, yellow cycles 8-10, all-red cycle 11.
   - Approach 1 green from cycle 12.
   - Full rotation = 48 cycles; lights returns to 0x02 at cycle 48.
2. Skip mode (skip_en=1, car_req=4'b1000 constant).
   - Sequence after approach 0: 0 → 3 → (no other request) green extension on 3, repeated every 8 cycles.
   - Approaches 1 and 2 never leave 00.
3. Emergency, other approach: emg_req=1, emg_dir=2 asserted at cycle 3 of approach 0 green.
   - Yellow on approach 0 at cycle 4 for 3 cycles, all-red 1 cycle.
   - Approach 2 green with emg_active=1 until release.
   - After release: 3 yellow cycles, 1 all-red, then approach 3 green.
4. Emergency, same approach: emg_dir=0 during approach 0 green.
   - Lamp stays 10 continuously; emg_active rises next cycle; green is held for 20 cycles of request.
5. Reset mid-yellow: rst=0 for 1 cycle while approach 2 is yellow.
   - Next cycle: lights=0x02, active_dir=0, emg_active=0.
   - Checker asserts that no cycle ever has two non-red lamps or code 11.
6. Parametric variant (NUM_DIR=3, GREEN_CYCLES=2, YELLOW_CYCLES=1, ALLRED_CYCLES=2).
   - Rotation 0 → 1 → 2 → 0 with a period of 15 cycles.
   - emg_dir=3 is ignored.
